// File: rtl/lutsr_rng_pkg.sv
// Shared types and elaboration-time helpers for the seeded LUT-SR random-bit generator.
package lutsr_rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_WARM = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // Depth of shift register i; the spread keeps neighbouring outputs decorrelated.
  function automatic int unsigned depth(input int unsigned i, input int unsigned k,
                                        input int unsigned kvar);
    return k - ((5 * i) % (kvar + 1));
  endfunction

  function automatic int unsigned seed_len(input int unsigned w, input int unsigned k,
                                           input int unsigned kvar);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < w; i++) s += depth(i, k, kvar);
    return s;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic bit tap_ok(input int unsigned w, input int unsigned t);
    return (t >= 1) && (t <= w - 1);
  endfunction

  // Taps must be in range and pairwise distinct, otherwise XOR terms cancel.
  function automatic bit taps_legal(input int unsigned w, input int unsigned t1,
                                    input int unsigned t2, input int unsigned t3,
                                    input int unsigned t4);
    return tap_ok(w, t1) && tap_ok(w, t2) && tap_ok(w, t3) && tap_ok(w, t4) &&
           (t1 != t2) && (t1 != t3) && (t1 != t4) &&
           (t2 != t3) && (t2 != t4) && (t3 != t4);
  endfunction

  function automatic bit shape_legal(input int unsigned w, input int unsigned k,
                                     input int unsigned kvar);
    return (w >= 16) && (w <= 128) && (k >= 2) && (k <= 32) && (kvar < k - 1);
  endfunction

endpackage

// File: rtl/lutsr_rng_sr.sv
// Clock-enabled shift register without reset, shaped so synthesis can map it onto one SRL.
module lutsr_rng_sr #(
  parameter int unsigned DEPTH = 32
) (
  input  logic clk,
  input  logic i_ce,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sr;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (i_ce) r_sr <= i_d;
    end
  end else begin : g_many
    always_ff @(posedge clk) begin
      if (i_ce) r_sr <= {r_sr[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/lutsr_rng_seeded.sv
// LUT-SR uniform random-bit generator with serial seeding, discarded warm-up,
// zero-seed rejection and a valid/ready word output.
module lutsr_rng_seeded
  import lutsr_rng_pkg::*;
#(
  parameter int unsigned W      = 64,
  parameter int unsigned K      = 32,
  parameter int unsigned KVAR   = 6,
  parameter int unsigned T1     = 7,
  parameter int unsigned T2     = 19,
  parameter int unsigned T3     = 41,
  parameter int unsigned T4     = 53,
  parameter int unsigned WARMUP = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         seed_start,
  input  logic         seed_bit,
  input  logic         seed_valid,
  output logic         seed_ready,
  output logic         seed_err,
  output logic [W-1:0] rng,
  output logic         rng_valid,
  input  logic         rng_ready
);

  localparam int unsigned SEED_LEN = seed_len(W, K, KVAR);
  localparam int unsigned CNT_W    = clog2(SEED_LEN + 1);
  localparam int unsigned WARM_W   = clog2(WARMUP + 1);

  if (!taps_legal(W, T1, T2, T3, T4) || !shape_legal(W, K, KVAR)) begin : g_bad_cfg
    $error("lutsr_rng_seeded: illegal W/K/KVAR or feedback taps");
  end

  state_t            r_state;
  logic              r_seed_ready;
  logic              r_seed_err;
  logic              r_rng_valid;
  logic              r_seed_or;
  logic [CNT_W-1:0]  r_seed_cnt;
  logic [WARM_W-1:0] r_warm_cnt;
  logic [W-1:0]      r_out;

  logic [W-1:0]      w_f;
  logic [W-1:0]      w_fb;
  logic [W-1:0]      w_sr_d;
  logic              w_seed_shift;
  logic              w_restart;
  logic              w_step;
  logic              w_sr_ce;
  logic              w_last_bit;

  assign w_seed_shift = (r_state == ST_SEED) && seed_valid;
  assign w_restart    = seed_start && (r_state != ST_SEED);
  assign w_step       = !seed_start &&
                        ((r_state == ST_WARM) ||
                         ((r_state == ST_RUN) && (rng_ready || !r_rng_valid)));
  assign w_sr_ce      = w_seed_shift || w_step;
  assign w_last_bit   = (r_seed_cnt == CNT_W'(SEED_LEN - 1));

  // During SEED the registers form one long chain; otherwise each is fed from r_out.
  for (genvar gi = 0; gi < W; gi++) begin : g_sr
    localparam int unsigned D   = depth(gi, K, KVAR);
    localparam int unsigned I1  = (gi + T1) % W;
    localparam int unsigned I2  = (gi + T2) % W;
    localparam int unsigned I3  = (gi + T3) % W;
    localparam int unsigned I4  = (gi + T4) % W;
    localparam int unsigned INX = (gi + 1) % W;

    logic w_chain;

    if (gi == 0) begin : g_head
      assign w_chain = seed_bit;
    end else begin : g_link
      assign w_chain = w_f[gi-1];
    end

    assign w_fb[gi]   = w_f[gi] ^ w_f[I1] ^ w_f[I2] ^ w_f[I3] ^ w_f[I4];
    assign w_sr_d[gi] = (r_state == ST_SEED) ? w_chain : r_out[INX];

    lutsr_rng_sr #(.DEPTH(D)) u_sr (
      .clk  (clk),
      .i_ce (w_sr_ce),
      .i_d  (w_sr_d[gi]),
      .o_q  (w_f[gi])
    );
  end

  // Output register is zero until the first warm-up step after a seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_restart || (r_state == ST_SEED) || (r_state == ST_IDLE)) begin
      r_out <= '0;
    end else if (w_step) begin
      r_out <= w_fb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_seed_ready <= 1'b0;
      r_seed_err   <= 1'b0;
      r_rng_valid  <= 1'b0;
      r_seed_or    <= 1'b0;
      r_seed_cnt   <= '0;
      r_warm_cnt   <= '0;
    end else begin
      r_seed_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (seed_start) begin
            r_state      <= ST_SEED;
            r_seed_ready <= 1'b1;
            r_seed_cnt   <= '0;
            r_seed_or    <= 1'b0;
          end
        end
        ST_SEED: begin
          if (seed_valid) begin
            if (w_last_bit) begin
              r_seed_ready <= 1'b0;
              r_seed_cnt   <= '0;
              if (r_seed_or || seed_bit) begin
                r_state    <= ST_WARM;
                r_warm_cnt <= '0;
              end else begin
                r_state    <= ST_IDLE;
                r_seed_err <= 1'b1;
              end
            end else begin
              r_seed_cnt <= r_seed_cnt + CNT_W'(1);
              r_seed_or  <= r_seed_or | seed_bit;
            end
          end
        end
        ST_WARM: begin
          if (seed_start) begin
            r_state      <= ST_SEED;
            r_seed_ready <= 1'b1;
            r_seed_cnt   <= '0;
            r_seed_or    <= 1'b0;
            r_warm_cnt   <= '0;
          end else if (r_warm_cnt == WARM_W'(WARMUP - 1)) begin
            r_state     <= ST_RUN;
            r_rng_valid <= 1'b1;
            r_warm_cnt  <= '0;
          end else begin
            r_warm_cnt <= r_warm_cnt + WARM_W'(1);
          end
        end
        ST_RUN: begin
          if (seed_start) begin
            r_state      <= ST_SEED;
            r_seed_ready <= 1'b1;
            r_rng_valid  <= 1'b0;
            r_seed_cnt   <= '0;
            r_seed_or    <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign seed_ready = r_seed_ready;
  assign seed_err   = r_seed_err;
  assign rng_valid  = r_rng_valid;
  assign rng        = r_out;

endmodule
